dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-master arbiter/sequencer in front of the byte-addressable data RAM wrapper (addr/datain/dataout/memop/we interface, synchronous read).
- Master 0 is the CPU load/store port; master 1 is the DMA/debug port, e.g. loader or VGA copy engine.
- Each access runs as a req/ack transaction. The arbiter latches the winning command, issues it to the RAM, waits out the read latency, then returns read data with a one-cycle ack.

Parameters:
- AW, 32, address width presented to RAM.
- DW, 32, data width.
- RD_LAT, 1, RAM read latency in clk cycles from issue to valid dataout (range 1..3).

Ports:
- clk  input  1  system clock; RAM rdclk/wrclk are driven from it externally.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- m0_req  input  1  master 0 request; held with command stable until m0_ack.
- m0_addr  input  AW  byte address.
- m0_wdata  input  DW  write data, right-aligned.
- m0_memop  input  3  access type, same encoding as RAM.
- m0_we  input  1  1=store, 0=load.
- m0_ack  output  1  one-cycle completion pulse.
- m0_rdata  output  DW  load result, valid when m0_ack=1.
- m0_err  output  1  pulses with m0_ack on an illegal memop.
- m1_req, m1_addr, m1_wdata, m1_memop, m1_we, m1_ack, m1_rdata, m1_err: same as m0_* for master 1.
- mem_addr  output  AW  to RAM addr.
- mem_datain  output  DW  to RAM datain.
- mem_memop  output  3  to RAM memop.
- mem_we  output  1  to RAM we.
- mem_dataout  input  DW  from RAM dataout.

Behaviour:
- Reset:
  - state=IDLE.
  - m*_ack=0, m*_err=0, m*_rdata=0.
  - mem_we=0, mem_addr=0, mem_datain=0, mem_memop=3'b010.
  - Round-robin pointer points at m0.
  - Reset mid-transaction aborts it: no ack is produced and mem_we drops in the same cycle reset is sampled.
- FSM: IDLE -> ISSUE -> (WAIT, loads only) -> ACK -> IDLE.
- IDLE:
  - If any req is high, select a winner and latch its addr/wdata/memop/we and its id into command registers, then go to ISSUE.
  - No req: stay in IDLE.
- ISSUE (1 cycle):
  - mem_* are driven from the latched command.
  - mem_we=1 only in this state, and only for a legal-memop store.
  - A store goes to ACK; a load goes to WAIT.
- WAIT:
  - Counter runs RD_LAT-1 further cycles; mem_addr/mem_memop are held.
  - mem_dataout is captured into the rdata register on the last WAIT cycle, then go to ACK.
- ACK (1 cycle):
  - Only the latched id sees ack=1; its rdata carries the captured value (0 for stores).
  - The requester samples ack at this edge and either drops req or presents its next command.
- Latency from req seen in IDLE: store ack at cycle +2; load ack at cycle +2+RD_LAT. One transaction in flight at a time.
- Outside ISSUE/WAIT, mem_addr/mem_datain/mem_memop hold their last values and mem_we=0.
- Illegal memop (011, 110, 111):
  - Transaction goes IDLE -> ISSUE -> ACK with mem_we forced 0.
  - rdata=0 and err=1 together with ack.
- Priority:
  - Simultaneous req with macro off: m0 wins.
  - A master whose req stays high is served again on the next IDLE.
  - Changing the command while waiting for ack is a protocol violation; the latched copy is used.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - On simultaneous requests, the master not served last wins.
  - The pointer updates in ACK to the other master.
  - A lone requester always wins.
- Undefined: fixed priority, m0 over m1; the pointer register is not synthesized.

Decomposition:
- Shared package/header:
  - MEMOP_LB=3'b000, MEMOP_LH=3'b001, MEMOP_LW=3'b010, MEMOP_LBU=3'b100, MEMOP_LHU=3'b101.
  - memop_legal function.
  - FSM state encoding ST_IDLE/ST_ISSUE/ST_WAIT/ST_ACK.
- One sub-module: dmem_arb_pick. It is combinational and takes req[1:0] plus the pointer and returns the grant id; it holds the macro-dependent logic.

Test Plan:
- m0 store LW addr 0x100 data 0xDEADBEEF, then m0 load LW 0x100 with RD_LAT=1:
  - mem_we high for exactly one cycle.
  - Load ack at req+3 with m0_rdata=0xDEADBEEF.
- m1 load LB addr 0x103 after store of 0x80FF0000 to 0x100 -> m1_rdata=0xFFFFFF80. LBU of the same address -> 0x00000080.
- m0 and m1 both request in the same cycle and hold req:
  - Macro off: order m0, m0, m0… while m0 holds.
  - Macro on: order m0, m1, m0, m1.
- m0 memop=3'b111 store -> mem_we never asserts; m0_ack=1 and m0_err=1 at req+2; m0_rdata=0.
- rst_n low during WAIT of an m1 load -> no m1_ack. Next cycle state=IDLE and all outputs equal their reset values; a fresh m0 request then completes normally.
- RD_LAT=3 load -> ack at req+5; mem_addr stable throughout ISSUE and WAIT.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-master data-RAM arbiter: memop encodings,
// the memop legality check and the sequencer state encoding.
package dmem_arbiter_pkg;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  function automatic logic memop_legal(input logic [2:0] op);
    return (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW) ||
           (op == MEMOP_LBU) || (op == MEMOP_LHU);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Grant selection between the two masters. ARB_ROUND_ROBIN_EN selects
// alternating priority on contention; otherwise master 0 always wins.
module dmem_arb_pick (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       gnt_id_o
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    if (&req_i) gnt_id_o = ptr_i;
    else        gnt_id_o = req_i[1];
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr_i;
  assign gnt_id_o   = ~req_i[0];
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master req/ack sequencer in front of the synchronous-read data RAM.
// ARB_ROUND_ROBIN_EN enables round-robin arbitration (see dmem_arb_pick).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          m0_req_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  input  logic [2:0]    m0_memop_i,
  input  logic          m0_we_i,
  output logic          m0_ack_o,
  output logic [DW-1:0] m0_rdata_o,
  output logic          m0_err_o,
  input  logic          m1_req_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic [2:0]    m1_memop_i,
  input  logic          m1_we_i,
  output logic          m1_ack_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          m1_err_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_datain_o,
  output logic [2:0]    mem_memop_o,
  output logic          mem_we_o,
  input  logic [DW-1:0] mem_dataout_i
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic          id_q, id_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [2:0]    memop_q, memop_d;
  logic          we_q, we_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    req;
  logic          gnt_id;
  logic          ptr;
  logic          legal;

  assign req   = {m1_req_i, m0_req_i};
  assign legal = memop_legal(memop_q);

  dmem_arb_pick u_pick (
    .req_i   (req),
    .ptr_i   (ptr),
    .gnt_id_o(gnt_id)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  assign ptr_d = (state_q == ST_ACK) ? ~id_q : ptr_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end
  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      id_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      memop_q <= MEMOP_LW;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      memop_q <= memop_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Illegal memops skip the read wait and go straight to the error ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (|req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = (we_q || !legal) ? ST_ACK : ST_WAIT;
      ST_WAIT:  if (cnt_q == '0) state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    id_d    = id_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    memop_d = memop_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          id_d    = gnt_id;
          addr_d  = gnt_id ? m1_addr_i  : m0_addr_i;
          wdata_d = gnt_id ? m1_wdata_i : m0_wdata_i;
          memop_d = gnt_id ? m1_memop_i : m0_memop_i;
          we_d    = gnt_id ? m1_we_i    : m0_we_i;
          rdata_d = '0;
        end
      end
      ST_ISSUE: cnt_d = CNT_INIT;
      ST_WAIT: begin
        if (cnt_q == '0) rdata_d = mem_dataout_i;
        else             cnt_d   = cnt_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_we_o   = (state_q == ST_ISSUE) && we_q && legal;
    m0_ack_o   = (state_q == ST_ACK) && !id_q;
    m1_ack_o   = (state_q == ST_ACK) && id_q;
    m0_err_o   = m0_ack_o && !legal;
    m1_err_o   = m1_ack_o && !legal;
    m0_rdata_o = m0_ack_o ? rdata_q : '0;
    m1_rdata_o = m1_ack_o ? rdata_q : '0;
  end

  assign mem_addr_o   = addr_q;
  assign mem_datain_o = wdata_q;
  assign mem_memop_o  = memop_q;

endmodule
